// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard detection, forwarding and memory-wait control for a 5-stage pipeline
// Optional feature macro: HAZARD_FORWARD_EN (operand forwarding; otherwise stall on EX/MEM dependencies)
`timescale 1ns/1ps

module pipeline_hazard_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [1:0]  ResultSrcE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        dmem_ready,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // wait_cnt lags the MEM_WAIT cycle count by one, so timeout is armed one count early
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t      state, state_next;
    logic [7:0]  wait_cnt;
    logic        wait_cond;
    logic        d_uses_e, d_uses_m;
    logic        load_use, dep_hazard, data_hazard;
    logic [1:0]  fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                           input logic ww, input logic [4:0] rdw);
        if (rs != 5'd0 && wm && rdm == rs)
            return 2'b10;
        else if (rs != 5'd0 && ww && rdw == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        d_uses_e    = (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
        d_uses_m    = (RdM != 5'd0) && (RdM == Rs1D || RdM == Rs2D);
        load_use    = (ResultSrcE == 2'b01) && RegWriteE && d_uses_e;
        dep_hazard  = (RegWriteE && d_uses_e) || (RegWriteM && d_uses_m);
        data_hazard = FWD_EN ? load_use : dep_hazard;
        fwd_a       = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
        fwd_b       = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        wait_cond   = !dmem_ready && (state == MEM_WAIT || MemReqM);
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (MemReqM && !dmem_ready) state_next = MEM_WAIT;
            MEM_WAIT: if (dmem_ready)             state_next = RUN;
            default:                              state_next = RUN;
        endcase
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!reset) begin
            ForwardAE = FWD_EN ? fwd_a : 2'b00;
            ForwardBE = FWD_EN ? fwd_b : 2'b00;
            if (wait_cond) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                // a redirect discards the dependent instruction, so it beats the data stall
                FlushD = PCSrcE;
                FlushE = PCSrcE || data_hazard;
                StallF = data_hazard && !PCSrcE;
                StallD = data_hazard && !PCSrcE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= 8'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= 32'd0;
        end else begin
            state <= state_next;
            if (state == RUN && state_next == MEM_WAIT)
                wait_cnt <= 8'd0;
            else if (state == MEM_WAIT && wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'd1;
            if (state == MEM_WAIT && wait_cnt >= WAIT_LAST)
                mem_timeout <= 1'b1;
            if (StallF && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
`timescale 1ns/1ps

module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteE, RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready;
    logic [1:0]  ResultSrcE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    pipeline_hazard_ctrl #(.WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwe, rwm, rww, pc;
        logic [1:0] rse;
        logic [3:0] stall_f, stall_n;
        logic [2:0] flush_f, flush_n;
        logic [1:0] fa, fb;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] stall;
        logic [2:0] flush;
        logic [1:0] fa, fb;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];

    function automatic vec_t mk(logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, logic rwe, logic [1:0] rse,
                                logic [4:0] rdm, logic rwm, logic [4:0] rdw, logic rww, logic pc,
                                logic [3:0] stall_f, logic [2:0] flush_f,
                                logic [3:0] stall_n, logic [2:0] flush_n, logic [1:0] fa, fb);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
        v.rwe = rwe; v.rse = rse; v.rdm = rdm; v.rwm = rwm; v.rdw = rdw; v.rww = rww; v.pc = pc;
        v.stall_f = stall_f; v.flush_f = flush_f; v.stall_n = stall_n; v.flush_n = flush_n;
        v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
        PCSrcE = 0; MemReqM = 0; dmem_ready = 0;
    endtask

    task automatic expect_out(string nm, logic [3:0] s, logic [2:0] f, logic [1:0] a, logic [1:0] b);
        exp_t e;
        e.name = nm; e.stall = s; e.flush = f;
        e.fa = FWD ? a : 2'b00;
        e.fb = FWD ? b : 2'b00;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        logic [12:0] act, req;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: no expected record queued");
            return;
        end
        e = sb.pop_front();
        act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};
        req = {e.stall, e.flush, e.fa, e.fb};
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got stall=%b flush=%b fa=%b fb=%b, expected stall=%b flush=%b fa=%b fb=%b",
                     e.name, act[12:9], act[8:6], act[5:4], act[3:2], e.stall, e.flush, e.fa, e.fb);
        end
    endtask

    task automatic chk32(string nm, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic step(string nm, logic [3:0] s, logic [2:0] f, logic [1:0] a, logic [1:0] b);
        expect_out(nm, s, f, a, b);
        #1;
        check_out();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rs1d rs2d rs1e rs2e rde rwe rse   rdm rwm rdw rww pc  stall_f  flush_f  stall_n  flush_n  fa     fb
        vecs[0]  = mk(0,   0,   0,   0,   0,  0,  2'b00, 0,  0,  0,  0,  0, 4'b0000, 3'b000, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[1]  = mk(5,   0,   0,   0,   5,  1,  2'b01, 0,  0,  0,  0,  0, 4'b1100, 3'b010, 4'b1100, 3'b010, 2'b00, 2'b00);
        vecs[2]  = mk(0,   9,   0,   0,   9,  1,  2'b01, 0,  0,  0,  0,  0, 4'b1100, 3'b010, 4'b1100, 3'b010, 2'b00, 2'b00);
        vecs[3]  = mk(5,   0,   0,   0,   5,  1,  2'b00, 0,  0,  0,  0,  0, 4'b0000, 3'b000, 4'b1100, 3'b010, 2'b00, 2'b00);
        vecs[4]  = mk(0,   0,   0,   0,   0,  1,  2'b01, 0,  0,  0,  0,  0, 4'b0000, 3'b000, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[5]  = mk(5,   0,   0,   0,   5,  1,  2'b01, 0,  0,  0,  0,  1, 4'b0000, 3'b110, 4'b0000, 3'b110, 2'b00, 2'b00);
        vecs[6]  = mk(0,   0,   0,   0,   0,  0,  2'b00, 0,  0,  0,  0,  1, 4'b0000, 3'b110, 4'b0000, 3'b110, 2'b00, 2'b00);
        vecs[7]  = mk(0,   0,   3,   0,   0,  0,  2'b00, 3,  1,  0,  0,  0, 4'b0000, 3'b000, 4'b0000, 3'b000, 2'b10, 2'b00);
        vecs[8]  = mk(0,   0,   0,   7,   0,  0,  2'b00, 7,  1,  7,  1,  0, 4'b0000, 3'b000, 4'b0000, 3'b000, 2'b00, 2'b10);
        vecs[9]  = mk(0,   0,   4,   0,   0,  0,  2'b00, 0,  0,  4,  1,  0, 4'b0000, 3'b000, 4'b0000, 3'b000, 2'b01, 2'b00);
        vecs[10] = mk(0,   0,   0,   0,   0,  0,  2'b00, 0,  1,  0,  1,  0, 4'b0000, 3'b000, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[11] = mk(0,   0,   0,   7,   0,  0,  2'b00, 7,  0,  7,  1,  0, 4'b0000, 3'b000, 4'b0000, 3'b000, 2'b00, 2'b01);
        vecs[12] = mk(0,   6,   0,   0,   0,  0,  2'b00, 6,  1,  0,  0,  0, 4'b0000, 3'b000, 4'b1100, 3'b010, 2'b00, 2'b00);
        vecs[13] = mk(5,   0,   0,   0,   5,  0,  2'b01, 0,  0,  0,  0,  0, 4'b0000, 3'b000, 4'b0000, 3'b000, 2'b00, 2'b00);
        vecs[14] = mk(0,   0,   8,   8,   0,  0,  2'b00, 8,  1,  8,  1,  0, 4'b0000, 3'b000, 4'b0000, 3'b000, 2'b10, 2'b10);
        vecs[15] = mk(4,   0,   0,   0,   0,  0,  2'b00, 0,  0,  4,  1,  0, 4'b0000, 3'b000, 4'b0000, 3'b000, 2'b00, 2'b00);

        // outputs gated during reset even with every hazard source active
        reset = 1'b1;
        idle();
        Rs1D = 5; Rs1E = 3; RdE = 5; RegWriteE = 1; ResultSrcE = 2'b01; RdM = 3; RegWriteM = 1;
        PCSrcE = 1; MemReqM = 1; dmem_ready = 0;
        @(negedge clk);
        step("reset_outputs", 4'b0000, 3'b000, 2'b00, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        chk32("reset_stall_cycles", stall_cycles, 32'd0);
        chk32("reset_mem_timeout", {31'd0, mem_timeout}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle();
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; RegWriteE = vecs[i].rwe; ResultSrcE = vecs[i].rse;
            RdM = vecs[i].rdm; RegWriteM = vecs[i].rwm; RdW = vecs[i].rdw; RegWriteW = vecs[i].rww;
            PCSrcE = vecs[i].pc;
            step($sformatf("vec%0d", i), FWD ? vecs[i].stall_f : vecs[i].stall_n,
                 FWD ? vecs[i].flush_f : vecs[i].flush_n, vecs[i].fa, vecs[i].fb);
        end

        // load x5 then dependent use: one stall cycle, then value arrives via MEM/WB
        do_reset();
        idle(); ResultSrcE = 2'b01; RegWriteE = 1; RdE = 5; Rs1D = 5;
        step("lu_stall", 4'b1100, 3'b010, 2'b00, 2'b00);
        @(negedge clk);
        idle(); RdM = 5; RegWriteM = 1; Rs1D = 5;
        step("lu_bubble", FWD ? 4'b0000 : 4'b1100, FWD ? 3'b000 : 3'b010, 2'b00, 2'b00);
        @(negedge clk);
        idle(); Rs1E = 5; RdW = 5; RegWriteW = 1;
        step("lu_forward", 4'b0000, 3'b000, 2'b01, 2'b00);
        @(negedge clk);
        idle();
        #1;
        chk32("lu_stall_cycles", stall_cycles, FWD ? 32'd1 : 32'd2);

        // 4-cycle memory wait
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); MemReqM = 1; dmem_ready = 0;
            step($sformatf("wait4_c%0d", i), 4'b1111, 3'b001, 2'b00, 2'b00);
            @(negedge clk);
        end
        idle(); MemReqM = 1; dmem_ready = 1;
        step("wait4_release", 4'b0000, 3'b000, 2'b00, 2'b00);
        @(negedge clk);
        idle();
        step("wait4_back_in_run", 4'b0000, 3'b000, 2'b00, 2'b00);
        chk32("wait4_stall_cycles", stall_cycles, 32'd4);

        // timeout after 15 MEM_WAIT cycles, sticky until reset
        do_reset();
        idle(); MemReqM = 1; dmem_ready = 0;
        step("to_enter", 4'b1111, 3'b001, 2'b00, 2'b00);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 15) chk32("to_before_limit", {31'd0, mem_timeout}, 32'd0);
            if (i == 16) chk32("to_at_limit", {31'd0, mem_timeout}, 32'd1);
        end
        chk32("to_stall_cycles", stall_cycles, 32'd20);
        @(negedge clk);
        idle(); dmem_ready = 1;
        step("to_release", 4'b0000, 3'b000, 2'b00, 2'b00);
        @(negedge clk);
        idle();
        #1;
        chk32("to_sticky", {31'd0, mem_timeout}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        MemReqM = 1; dmem_ready = 0; PCSrcE = 1;
        step("to_reset_outputs", 4'b0000, 3'b000, 2'b00, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        chk32("to_cleared", {31'd0, mem_timeout}, 32'd0);
        chk32("to_cnt_cleared", stall_cycles, 32'd0);

        // branch held during a wait applies on release; reset mid-wait
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); PCSrcE = 1; MemReqM = 1; dmem_ready = 0;
            step($sformatf("br_wait_c%0d", i), 4'b1111, 3'b001, 2'b00, 2'b00);
            @(negedge clk);
        end
        idle(); PCSrcE = 1; MemReqM = 1; dmem_ready = 1;
        step("br_release", 4'b0000, 3'b110, 2'b00, 2'b00);
        @(negedge clk);
        idle(); MemReqM = 1; dmem_ready = 0;
        step("rw_enter", 4'b1111, 3'b001, 2'b00, 2'b00);
        @(negedge clk);
        idle(); MemReqM = 1; dmem_ready = 0;
        step("rw_in_wait", 4'b1111, 3'b001, 2'b00, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        step("rw_reset", 4'b0000, 3'b000, 2'b00, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        idle();
        step("rw_run_after", 4'b0000, 3'b000, 2'b00, 2'b00);
        chk32("rw_stall_cycles", stall_cycles, 32'd0);
        chk32("rw_mem_timeout", {31'd0, mem_timeout}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
